// File: rtl/accu_trace_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : accu_trace_buffer                                             |
// | Description : Samples the core PC/accumulator every clock and records        |
// |               {pc, accu} into a small FIFO whenever the accumulator value     |
// |               changes. A debug consumer drains entries over valid/ready.     |
// |               Optional macro TRACE_TRIGGER_EN: recording is held off until   |
// |               the PC reaches TRIG_ADDR, then stays on until clear/reset.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module accu_trace_buffer #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int TRIG_ADDR  = 0
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [ADDR_WIDTH-1:0]          pc_addr_i,
  input  logic [DATA_WIDTH-1:0]          accu_i,
  input  logic                           clear_i,
  output logic                           rd_valid_o,
  input  logic                           rd_ready_i,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] rd_data_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           overflow_o,
  output logic [7:0]                     drop_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic [7:0]            drop_cnt;
  logic [DATA_WIDTH-1:0] prev_accu;
  logic                  prev_vld;

  logic recording;
  logic changed;
  logic push;
  logic pop;
  logic full;
  logic store;
  logic drop;

`ifdef TRACE_TRIGGER_EN
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } trig_state_t;

  trig_state_t state;
  trig_state_t state_next;

  // Trigger state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Trigger next-state: arm on the trigger PC, the arming sample is itself recorded.
  always_comb begin
    state_next = state;
    recording  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pc_addr_i == ADDR_WIDTH'(TRIG_ADDR)) begin
          state_next = S_ARMED;
          recording  = 1'b1;
        end
      end
      S_ARMED: begin
        recording = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (clear_i) begin
      state_next = S_IDLE;
    end
  end
`else
  logic unused_trig_addr;
  assign unused_trig_addr = ^ADDR_WIDTH'(TRIG_ADDR);
  assign recording        = 1'b1;
`endif

  // Push/pop qualification; clear overrides both.
  always_comb begin
    changed = !prev_vld || (accu_i != prev_accu);
    push    = recording && changed && !clear_i;
    pop     = (count != '0) && rd_ready_i && !clear_i;
    full    = (count == CNT_W'(DEPTH));
    store   = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // Storage array; contents need no reset because the head is only meaningful when valid.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= {pc_addr_i, accu_i};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (store && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !store) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Previous-sample tracker used for change detection.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      prev_accu <= '0;
      prev_vld  <= 1'b0;
    end else if (clear_i) begin
      prev_vld  <= 1'b0;
    end else if (recording) begin
      prev_accu <= accu_i;
      prev_vld  <= 1'b1;
    end
  end

  assign rd_valid_o = (count != '0);
  assign rd_data_o  = mem[rd_ptr];
  assign count_o    = count;
  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_accu_trace_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_accu_trace_buffer                                          |
// | Description : Self-checking bench for accu_trace_buffer against a queue     |
// |               based reference model (honours TRACE_TRIGGER_EN).              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_accu_trace_buffer;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int TRIG  = 47;

  logic          clk;
  logic          nReset;
  logic [AW-1:0] pc_addr_i;
  logic [DW-1:0] accu_i;
  logic          clear_i;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [AW+DW-1:0] rd_data_o;
  logic [$clog2(DEPTH):0] count_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  accu_trace_buffer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .TRIG_ADDR (TRIG)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .pc_addr_i (pc_addr_i),
    .accu_i    (accu_i),
    .clear_i   (clear_i),
    .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i),
    .rd_data_o (rd_data_o),
    .count_o   (count_o),
    .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [AW+DW-1:0] mq[$];
  int               m_drop;
  bit               m_ovf;
  bit               m_pvld;
  logic [DW-1:0]    m_prev;
  bit               m_armed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_drop  = 0;
    m_ovf   = 0;
    m_pvld  = 0;
    m_prev  = '0;
    m_armed = 0;
  endfunction

  // Behaviour of one rising edge given the inputs currently applied.
  function automatic void model_edge();
    bit rec, push, pop, full;
    if (!nReset) begin
      model_reset();
      return;
    end
    if (clear_i) begin
      mq.delete();
      m_drop  = 0;
      m_ovf   = 0;
      m_pvld  = 0;
      m_armed = 0;
      return;
    end
`ifdef TRACE_TRIGGER_EN
    rec = m_armed || (int'(pc_addr_i) == TRIG);
`else
    rec = 1;
`endif
    push = rec && (!m_pvld || accu_i != m_prev);
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rd_ready_i;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back({pc_addr_i, accu_i});
      end
    end
    if (rec) begin
      m_prev  = accu_i;
      m_pvld  = 1;
      m_armed = 1;
    end
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ":count"}, 32'(count_o), 32'(mq.size()));
    chk({ph, ":valid"}, 32'(rd_valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({ph, ":data"}, 32'(rd_data_o), 32'(mq[0]));
    chk({ph, ":ovf"}, 32'(overflow_o), 32'(m_ovf));
    chk({ph, ":drop"}, 32'(drop_cnt_o), 32'(m_drop));
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic set_in(input int pc, input int acc, input bit rdy, input bit clr);
    pc_addr_i  = AW'(pc);
    accu_i     = DW'(acc);
    rd_ready_i = rdy;
    clear_i    = clr;
  endtask

  logic [AW+DW-1:0] exp_t2[5];
  int               n_exp;
  int               t2_pc[5];
  int               t2_acc[5];

  initial begin
    t2_pc  = '{45, 46, 47, 48, 49};
    t2_acc = '{85, 80, 240, 255, 0};
`ifdef TRACE_TRIGGER_EN
    n_exp = 3;
    for (int i = 0; i < 3; i++) exp_t2[i] = {AW'(t2_pc[i+2]), DW'(t2_acc[i+2])};
`else
    n_exp = 5;
    for (int i = 0; i < 5; i++) exp_t2[i] = {AW'(t2_pc[i]), DW'(t2_acc[i])};
`endif

    // T1: reset asserted with random inputs, outputs settle without any clock
    nReset = 1'b0;
    set_in($urandom_range(63), $urandom_range(255), 1'($urandom), 1'b0);
    model_reset();
    #1;
    check_all("t1");
    chk("t1:count0", 32'(count_o), 32'd0);
    cycle("t1h");
    cycle("t1h");
    nReset = 1'b1;

    // T2: program trace without reads
    for (int i = 0; i < 5; i++) begin
      set_in(t2_pc[i], t2_acc[i], 1'b0, 1'b0);
      cycle("t2push");
    end
    chk("t2:count", 32'(count_o), 32'(n_exp));
    set_in(50, 0, 1'b1, 1'b0);
    for (int i = 0; i < n_exp; i++) begin
      chk("t2:order", 32'(rd_data_o), 32'(exp_t2[i]));
      cycle("t2pop");
    end
    chk("t2:empty", 32'(rd_valid_o), 32'd0);

    // T3: held accumulator across PC changes yields a single entry
    set_in(47, 0, 1'b0, 1'b1);
    cycle("t3clr");
    for (int i = 0; i < 20; i++) begin
      set_in(47 + (i % 3), 8'h55, 1'b0, 1'b0);
      cycle("t3");
    end
    chk("t3:one", 32'(count_o), 32'd1);

    // T4: overflow with 11 distinct values, then push+pop at full
    set_in(47, 0, 1'b0, 1'b1);
    cycle("t4clr");
    for (int i = 0; i < 11; i++) begin
      set_in(47, i + 1, 1'b0, 1'b0);
      cycle("t4");
    end
    chk("t4:full", 32'(count_o), 32'd8);
    chk("t4:ovf", 32'(overflow_o), 32'd1);
    chk("t4:drop", 32'(drop_cnt_o), 32'd3);
    set_in(47, 100, 1'b1, 1'b0);
    cycle("t4pp");
    chk("t4:ppcount", 32'(count_o), 32'd8);
    chk("t4:ppdrop", 32'(drop_cnt_o), 32'd3);

    // T5: clear beats push/pop, next sample is a first sample
    set_in(47, 0, 1'b0, 1'b1);
    cycle("t5clr");
    for (int i = 0; i < 4; i++) begin
      set_in(47, 10 + i, 1'b0, 1'b0);
      cycle("t5fill");
    end
    set_in(47, 77, 1'b1, 1'b1);
    cycle("t5clear");
    chk("t5:count", 32'(count_o), 32'd0);
    chk("t5:ovf", 32'(overflow_o), 32'd0);
    set_in(47, 77, 1'b0, 1'b0);
    cycle("t5first");
    chk("t5:first", 32'(count_o), 32'd1);

    // Drop counter saturation
    for (int i = 0; i < 270; i++) begin
      set_in(47, (i % 2) ? 8'hA5 : 8'h5A, 1'b0, 1'b0);
      cycle("sat");
    end
    chk("sat:drop", 32'(drop_cnt_o), 32'd255);

    // Randomised traffic with occasional clear and an async reset mid-stream
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(63), $urandom_range(3), 1'($urandom_range(2) == 0),
             ($urandom_range(40) == 0));
      if (i == 200) begin
        nReset = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        cycle("arsth");
        nReset = 1'b1;
      end else begin
        cycle("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
